// File: rtl/battleship_scoreboard_if.sv
// battleship_scoreboard_if: shot reporting inputs and display driver outputs of the scoreboard
interface battleship_scoreboard_if;
    logic       clear;
    logic       shot_valid;
    logic       shot_player;
    logic       shot_hit;
    logic [3:0] BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0;
    logic [7:0] blank;
    logic       game_over;
    logic       winner;
    modport master (
        output clear, shot_valid, shot_player, shot_hit,
        input  BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0, blank, game_over, winner
    );
    modport slave (
        input  clear, shot_valid, shot_player, shot_hit,
        output BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0, blank, game_over, winner
    );
endinterface

// File: rtl/battleship_scoreboard.sv
// battleship_scoreboard: BCD shot/hit counters per player, game-over detection and
// digit blanking (leading zeros, flashing winner) for the eight-digit display driver
module battleship_scoreboard #(
    parameter int HITS_TO_WIN  = 17,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input logic                    clock,
    input logic                    reset_L,
    battleship_scoreboard_if.slave bus
);
    localparam int CW = $clog2(BLINK_CYCLES);
    localparam logic [7:0] WIN_BCD = {4'(HITS_TO_WIN / 10), 4'(HITS_TO_WIN % 10)};
    typedef enum logic {PLAY, OVER} state_t;
    state_t        r_state;
    logic [7:0]    r_s1, r_h1, r_s2, r_h2;
    logic          r_winner, r_phase;
    logic [CW-1:0] r_cnt;
    logic [7:0]    w_s_nxt, w_h_nxt;
    logic          w_flash1, w_flash2;
    // Saturating 2-digit BCD increment; 99 sticks
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return v == 8'h99 ? v : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction
    always_comb begin
        w_s_nxt = bcd_inc(bus.shot_player ? r_s2 : r_s1);
        w_h_nxt = bcd_inc(bus.shot_player ? r_h2 : r_h1);
    end
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_state  <= PLAY;
            r_s1     <= '0;
            r_h1     <= '0;
            r_s2     <= '0;
            r_h2     <= '0;
            r_winner <= 1'b0;
            r_phase  <= 1'b0;
            r_cnt    <= '0;
        end else if (bus.clear) begin
            r_state  <= PLAY;
            r_s1     <= '0;
            r_h1     <= '0;
            r_s2     <= '0;
            r_h2     <= '0;
            r_winner <= 1'b0;
            r_phase  <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == PLAY) begin
            if (bus.shot_valid) begin
                if (bus.shot_player) r_s2 <= w_s_nxt;
                else                 r_s1 <= w_s_nxt;
                if (bus.shot_hit) begin
                    if (bus.shot_player) r_h2 <= w_h_nxt;
                    else                 r_h1 <= w_h_nxt;
                    if (w_h_nxt == WIN_BCD) begin
                        r_state  <= OVER;
                        r_winner <= bus.shot_player;
                        r_phase  <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
            end
        end else if (r_cnt == CW'(BLINK_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
    assign w_flash1      = r_state == OVER && r_phase && !r_winner;
    assign w_flash2      = r_state == OVER && r_phase && r_winner;
    assign bus.BCD7      = r_s1[7:4];
    assign bus.BCD6      = r_s1[3:0];
    assign bus.BCD5      = r_h1[7:4];
    assign bus.BCD4      = r_h1[3:0];
    assign bus.BCD3      = r_s2[7:4];
    assign bus.BCD2      = r_s2[3:0];
    assign bus.BCD1      = r_h2[7:4];
    assign bus.BCD0      = r_h2[3:0];
    assign bus.game_over = r_state == OVER;
    assign bus.winner    = r_winner;
    // Tens digits dark on zero; the winner's whole half goes dark on the flash phase
    assign bus.blank = {{4{w_flash1}} | {r_s1[7:4] == 4'd0, 1'b0, r_h1[7:4] == 4'd0, 1'b0},
                        {4{w_flash2}} | {r_s2[7:4] == 4'd0, 1'b0, r_h2[7:4] == 4'd0, 1'b0}};
endmodule
